// File: rtl/yuv2rgb_pipe.sv
// yuv2rgb_pipe
//   Three-stage YUV 4:4:4 -> RGB converter with valid/ready flow control.
//   S1: offset-removed operands + mode, S2: five products, S3: sums, clip,
//   clip flags (S3 drives the outputs). The whole pipe advances together
//   whenever the output register is empty or being drained.
// Ports
//   CLOCK_50_I            clock
//   reset                 asynchronous active-high reset
//   in_valid / in_ready   input handshake (in_ready = ~out_valid | out_ready)
//   full_range            0 = studio (BT.601) set, 1 = full-range set, per pixel
//   Y_in, U_in, V_in      unsigned input components
//   out_valid / out_ready output handshake
//   R_out, G_out, B_out   clipped unsigned output components
//   clear_stats           synchronous clear of clip_count (wins over increment)
//   clip_count            saturating count of clipped components delivered
module yuv2rgb_pipe #(
    parameter int IN_W    = 8,
    parameter int COEFF_W = 18,
    parameter int FRAC    = 16,
    parameter int ROUND   = 0
) (
    input  logic            CLOCK_50_I,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            full_range,
    input  logic [IN_W-1:0] Y_in,
    input  logic [IN_W-1:0] U_in,
    input  logic [IN_W-1:0] V_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IN_W-1:0] R_out,
    output logic [IN_W-1:0] G_out,
    output logic [IN_W-1:0] B_out,
    input  logic            clear_stats,
    output logic [15:0]     clip_count
);

    localparam int STAGES = 3;
    localparam int NUM_CH = 3;
    localparam int OP_W   = IN_W + 1;
    localparam int PROD_W = OP_W + COEFF_W + 1;
    localparam int ACC_W  = IN_W + COEFF_W + 4;

    // Q16 constants rescaled to the configured fractional width, truncated.
    function automatic logic [COEFF_W-1:0] qscale(input longint q16);
        longint s;
        if (FRAC >= 16) s = q16 <<< (FRAC - 16);
        else            s = q16 >>> (16 - FRAC);
        return s[COEFF_W-1:0];
    endfunction

    localparam logic [COEFF_W-1:0] ST_CY  = qscale(64'd76284);
    localparam logic [COEFF_W-1:0] ST_CRV = qscale(64'd104595);
    localparam logic [COEFF_W-1:0] ST_CGU = qscale(64'd25624);
    localparam logic [COEFF_W-1:0] ST_CGV = qscale(64'd53281);
    localparam logic [COEFF_W-1:0] ST_CBU = qscale(64'd132251);
    localparam logic [COEFF_W-1:0] FR_CY  = qscale(64'd65536);
    localparam logic [COEFF_W-1:0] FR_CRV = qscale(64'd91881);
    localparam logic [COEFF_W-1:0] FR_CGU = qscale(64'd22554);
    localparam logic [COEFF_W-1:0] FR_CGV = qscale(64'd46802);
    localparam logic [COEFF_W-1:0] FR_CBU = qscale(64'd116130);

    localparam logic [IN_W-1:0]         Y_OFF = IN_W'(16 << (IN_W - 8));
    localparam logic [IN_W-1:0]         C_OFF = IN_W'(1 << (IN_W - 1));
    localparam logic signed [ACC_W-1:0] RND   = (ROUND != 0) ? (ACC_W'(1) << (FRAC - 1)) : '0;

    typedef struct packed {
        logic signed [OP_W-1:0] y;
        logic signed [OP_W-1:0] u;
        logic signed [OP_W-1:0] v;
        logic                   fr;
    } op_t;

    typedef struct packed {
        logic signed [PROD_W-1:0] y;
        logic signed [PROD_W-1:0] rv;
        logic signed [PROD_W-1:0] gu;
        logic signed [PROD_W-1:0] gv;
        logic signed [PROD_W-1:0] bu;
    } prod_t;

    // Coefficients are unsigned; a zero sign bit keeps the product signed.
    function automatic logic signed [PROD_W-1:0] mul(input logic [COEFF_W-1:0] c,
                                                     input logic signed [OP_W-1:0] x);
        return PROD_W'($signed({1'b0, c})) * PROD_W'(x);
    endfunction

    logic [STAGES:1] vld_pipe;
    logic            adv;

    assign adv       = ~vld_pipe[STAGES] | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[STAGES];

    // S1: offset removal
    op_t op_d, op_q;
    always_comb begin
        op_d.fr = full_range;
        op_d.y  = $signed({1'b0, Y_in}) - $signed({1'b0, full_range ? {IN_W{1'b0}} : Y_OFF});
        op_d.u  = $signed({1'b0, U_in}) - $signed({1'b0, C_OFF});
        op_d.v  = $signed({1'b0, V_in}) - $signed({1'b0, C_OFF});
    end

    // S2: products, coefficient set chosen by the mode travelling with the pixel
    prod_t pr_d, pr_q;
    always_comb begin
        pr_d.y  = mul(op_q.fr ? FR_CY  : ST_CY,  op_q.y);
        pr_d.rv = mul(op_q.fr ? FR_CRV : ST_CRV, op_q.v);
        pr_d.gu = mul(op_q.fr ? FR_CGU : ST_CGU, op_q.u);
        pr_d.gv = mul(op_q.fr ? FR_CGV : ST_CGV, op_q.v);
        pr_d.bu = mul(op_q.fr ? FR_CBU : ST_CBU, op_q.u);
    end

    // S3: sums (lane 0 = R, 1 = G, 2 = B), rounding, shift and clip
    logic [NUM_CH-1:0][ACC_W-1:0] acc;
    always_comb begin
        acc[0] = ACC_W'(pr_q.y) + ACC_W'(pr_q.rv) + RND;
        acc[1] = ACC_W'(pr_q.y) - ACC_W'(pr_q.gu) - ACC_W'(pr_q.gv) + RND;
        acc[2] = ACC_W'(pr_q.y) + ACC_W'(pr_q.bu) + RND;
    end

    logic [NUM_CH-1:0][IN_W-1:0] rgb_d, rgb_q;
    logic [NUM_CH-1:0]           flg_d, flg_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_clip
        logic signed [ACC_W-1:0] sh;
        logic                    neg, ovf;
        assign sh       = $signed(acc[c]) >>> FRAC;
        assign neg      = sh[ACC_W-1];
        // Positive and any bit above the output width set -> too large.
        assign ovf      = ~neg & (|sh[ACC_W-2:IN_W]);
        assign flg_d[c] = neg | ovf;
        assign rgb_d[c] = neg ? '0 : (ovf ? '1 : sh[IN_W-1:0]);
    end

    always_ff @(posedge CLOCK_50_I or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            op_q     <= '0;
            pr_q     <= '0;
            rgb_q    <= '0;
            flg_q    <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            op_q     <= op_d;
            pr_q     <= pr_d;
            rgb_q    <= rgb_d;
            flg_q    <= flg_d;
        end
    end

    assign R_out = rgb_q[0];
    assign G_out = rgb_q[1];
    assign B_out = rgb_q[2];

    // Clip statistics, counted only on delivered pixels
    logic [1:0]  n_clip;
    logic [16:0] cnt_sum;
    assign n_clip  = {1'b0, flg_q[0]} + {1'b0, flg_q[1]} + {1'b0, flg_q[2]};
    assign cnt_sum = {1'b0, clip_count} + {15'd0, n_clip};

    always_ff @(posedge CLOCK_50_I or posedge reset) begin
        if (reset)                      clip_count <= '0;
        else if (clear_stats)           clip_count <= '0;
        else if (out_valid & out_ready) clip_count <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

endmodule

// File: tb/tb_yuv2rgb_pipe.sv
module tb_yuv2rgb_pipe;

    logic       CLOCK_50_I = 1'b0;
    logic       reset;
    logic       in_valid, out_ready, full_range, clear_stats;
    logic [7:0] yin, uin, vin;
    logic       rdy0, rdy1, ov0, ov1;
    logic [7:0] r0, g0, b0, r1, g1, b1;
    logic [15:0] cc0, cc1;

    always #5 CLOCK_50_I = ~CLOCK_50_I;

    // dut truncates, dut_r rounds; both see the same stimulus
    yuv2rgb_pipe #(.IN_W(8), .COEFF_W(18), .FRAC(16), .ROUND(0)) dut (
        .CLOCK_50_I(CLOCK_50_I), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
        .full_range(full_range), .Y_in(yin), .U_in(uin), .V_in(vin),
        .out_valid(ov0), .out_ready(out_ready), .R_out(r0), .G_out(g0), .B_out(b0),
        .clear_stats(clear_stats), .clip_count(cc0));

    yuv2rgb_pipe #(.IN_W(8), .COEFF_W(18), .FRAC(16), .ROUND(1)) dut_r (
        .CLOCK_50_I(CLOCK_50_I), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
        .full_range(full_range), .Y_in(yin), .U_in(uin), .V_in(vin),
        .out_valid(ov1), .out_ready(out_ready), .R_out(r1), .G_out(g1), .B_out(b1),
        .clear_stats(clear_stats), .clip_count(cc1));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0] y, u, v;
        logic       fr;
    } smp_t;

    typedef struct packed {
        logic [7:0] r, g, b;
        logic [1:0] n;
    } px_t;

    // Reference: the conversion equations in plain integer arithmetic
    function automatic px_t model(input smp_t s, input logic rnd);
        longint cy, crv, cgu, cgv, cbu, yp, up, vp, sh;
        longint a [3];
        logic [7:0] c [3];
        px_t p;
        int n;
        if (s.fr) begin cy = 65536; crv = 91881;  cgu = 22554; cgv = 46802; cbu = 116130; end
        else      begin cy = 76284; crv = 104595; cgu = 25624; cgv = 53281; cbu = 132251; end
        yp = longint'(s.y) - (s.fr ? 0 : 16);
        up = longint'(s.u) - 128;
        vp = longint'(s.v) - 128;
        a[0] = cy * yp + crv * vp;
        a[1] = cy * yp - cgu * up - cgv * vp;
        a[2] = cy * yp + cbu * up;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            sh = (a[i] + (rnd ? 32768 : 0)) >>> 16;
            if (sh < 0)        begin c[i] = 8'd0;   n++; end
            else if (sh > 255) begin c[i] = 8'd255; n++; end
            else                     c[i] = sh[7:0];
        end
        p.r = c[0]; p.g = c[1]; p.b = c[2]; p.n = 2'(n);
        return p;
    endfunction

    // Monitor: sampled on the falling edge, describing the coming rising edge
    smp_t q[$];
    int   n_acc = 0;
    int   cnt0 = 0, cnt1 = 0;
    logic prev_stall = 1'b0;
    logic [7:0] hr0, hg0, hb0, hr1, hg1, hb1;

    always @(negedge CLOCK_50_I) begin
        smp_t e;
        px_t  m0, m1;
        int   n0, n1;
        if (reset) begin
            q.delete();
            cnt0 = 0; cnt1 = 0;
            prev_stall = 1'b0;
        end else begin
            chk("clip_cnt", 32'(cc0), 32'(cnt0));
            chk("clip_cnt_r", 32'(cc1), 32'(cnt1));
            if (prev_stall) begin
                chk("hold_ov", 32'(ov0), 32'd1);
                chk("hold_r", 32'(r0), 32'(hr0)); chk("hold_g", 32'(g0), 32'(hg0)); chk("hold_b", 32'(b0), 32'(hb0));
                chk("hold_r_rnd", 32'(r1), 32'(hr1)); chk("hold_g_rnd", 32'(g1), 32'(hg1)); chk("hold_b_rnd", 32'(b1), 32'(hb1));
            end
            n0 = 0; n1 = 0;
            if (ov0 && out_ready) begin
                if (q.size() == 0) chk("spurious_out", 32'(q.size()), 32'd1);
                else begin
                    e  = q.pop_front();
                    m0 = model(e, 1'b0);
                    m1 = model(e, 1'b1);
                    chk("ov_rnd", 32'(ov1), 32'd1);
                    chk("R", 32'(r0), 32'(m0.r)); chk("G", 32'(g0), 32'(m0.g)); chk("B", 32'(b0), 32'(m0.b));
                    chk("R_rnd", 32'(r1), 32'(m1.r)); chk("G_rnd", 32'(g1), 32'(m1.g)); chk("B_rnd", 32'(b1), 32'(m1.b));
                    n0 = int'(m0.n); n1 = int'(m1.n);
                end
            end
            if (clear_stats) begin cnt0 = 0; cnt1 = 0; end
            else if (ov0 && out_ready) begin
                cnt0 = (cnt0 + n0 > 65535) ? 65535 : cnt0 + n0;
                cnt1 = (cnt1 + n1 > 65535) ? 65535 : cnt1 + n1;
            end
            if (in_valid && rdy0) begin
                e.y = yin; e.u = uin; e.v = vin; e.fr = full_range;
                q.push_back(e);
                n_acc++;
            end
            prev_stall = ov0 && !out_ready;
            hr0 = r0; hg0 = g0; hb0 = b0; hr1 = r1; hg1 = g1; hb1 = b1;
        end
    end

    task automatic drive(input logic [7:0] y, input logic [7:0] u, input logic [7:0] v, input logic fr);
        yin = y; uin = u; vin = v; full_range = fr;
    endtask

    // Sample driven just after edge E is captured at E+1 and appears after E+3.
    task automatic send_one(input string tag, input logic [7:0] y, input logic [7:0] u, input logic [7:0] v,
                            input logic fr, input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb,
                            input logic [7:0] err, input logic [7:0] egr, input logic [7:0] ebr);
        @(posedge CLOCK_50_I); #1;
        drive(y, u, v, fr); in_valid = 1'b1;
        chk({tag, "_rdy"}, 32'(rdy0), 32'd1);
        chk({tag, "_rdy_rnd"}, 32'(rdy1), 32'd1);
        @(posedge CLOCK_50_I); #1; in_valid = 1'b0;
        chk({tag, "_lat1"}, 32'(ov0), 32'd0);
        @(posedge CLOCK_50_I); #1;
        chk({tag, "_lat2"}, 32'(ov0), 32'd0);
        @(posedge CLOCK_50_I); #1;
        chk({tag, "_lat3"}, 32'(ov0), 32'd1);
        chk({tag, "_R"}, 32'(r0), 32'(er)); chk({tag, "_G"}, 32'(g0), 32'(eg)); chk({tag, "_B"}, 32'(b0), 32'(eb));
        chk({tag, "_R_rnd"}, 32'(r1), 32'(err)); chk({tag, "_G_rnd"}, 32'(g1), 32'(egr)); chk({tag, "_B_rnd"}, 32'(b1), 32'(ebr));
    endtask

    task automatic drain(input string tag);
        int k = 0;
        in_valid = 1'b0; out_ready = 1'b1;
        while (q.size() != 0 && k < 200) begin @(posedge CLOCK_50_I); #1; k++; end
        chk({tag, "_drained"}, 32'(q.size()), 32'd0);
        chk({tag, "_idle"}, 32'(ov0), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached before finish");
        $fatal(1, "time limit");
    end

    initial begin
        int a0;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clear_stats = 1'b0;
        drive(8'd0, 8'd0, 8'd0, 1'b0);
        repeat (3) @(posedge CLOCK_50_I); #1;
        chk("rst_ov", 32'(ov0), 32'd0); chk("rst_ov_rnd", 32'(ov1), 32'd0);
        chk("rst_rgb", {8'd0, r0, g0, b0}, 32'd0);
        chk("rst_cnt", 32'(cc0), 32'd0);
        reset = 1'b0;
        #1 chk("rdy_after_rst", 32'(rdy0), 32'd1);

        send_one("black", 8'd16, 8'd128, 8'd128, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        @(posedge CLOCK_50_I); #1;
        chk("black_cnt", 32'(cc0), 32'd0);
        send_one("white", 8'd235, 8'd128, 8'd128, 1'b0, 8'd254, 8'd254, 8'd254, 8'd255, 8'd255, 8'd255);
        send_one("red", 8'd81, 8'd90, 8'd240, 1'b0, 8'd254, 8'd0, 8'd0, 8'd254, 8'd0, 8'd0);
        @(posedge CLOCK_50_I); #1;
        chk("red_cnt", 32'(cc0), 32'd2);
        chk("red_cnt_rnd", 32'(cc1), 32'd2);
        send_one("grey_fr", 8'd128, 8'd128, 8'd128, 1'b1, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128);
        drain("directed");

        // Mode toggling every pixel with no flush
        a0 = n_acc;
        for (int i = 0; i < 64; i++) begin
            @(posedge CLOCK_50_I); #1;
            drive(8'($urandom), 8'($urandom), 8'($urandom), i[0]);
            in_valid = 1'b1;
        end
        @(posedge CLOCK_50_I); #1; in_valid = 1'b0;
        chk("alt_count", 32'(n_acc - a0), 32'd64);
        drain("alt");

        // Random valid/ready, 10k samples
        a0 = n_acc;
        for (int k = 0; k < 60000 && (n_acc - a0) < 10000; k++) begin
            @(posedge CLOCK_50_I); #1;
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 70);
            drive(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        chk("rand_count", 32'(n_acc - a0), 32'd10000);
        drain("rand");

        // Reset with three samples in flight
        for (int i = 0; i < 3; i++) begin
            @(posedge CLOCK_50_I); #1;
            drive(8'd0, 8'd128, 8'd128, 1'b0); in_valid = 1'b1;
        end
        @(posedge CLOCK_50_I); #1; in_valid = 1'b0;
        chk("inflight_ov", 32'(ov0), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_ov", 32'(ov0), 32'd0); chk("midrst_ov_rnd", 32'(ov1), 32'd0);
        chk("midrst_cnt", 32'(cc0), 32'd0); chk("midrst_cnt_rnd", 32'(cc1), 32'd0);
        chk("midrst_rgb", {8'd0, r0, g0, b0}, 32'd0);
        @(posedge CLOCK_50_I); #1; reset = 1'b0;
        repeat (4) @(posedge CLOCK_50_I); #1;
        chk("no_ghost", 32'(ov0), 32'd0);

        // Sustained 3-component clipping until saturation
        drive(8'd0, 8'd128, 8'd128, 1'b0); in_valid = 1'b1; out_ready = 1'b1;
        repeat (21900) @(posedge CLOCK_50_I); #1;
        chk("sat", 32'(cc0), 32'hFFFF); chk("sat_rnd", 32'(cc1), 32'hFFFF);
        clear_stats = 1'b1;
        chk("clr_busy", 32'(ov0), 32'd1);
        @(posedge CLOCK_50_I); #1; clear_stats = 1'b0;
        chk("clr_prio", 32'(cc0), 32'd0); chk("clr_prio_rnd", 32'(cc1), 32'd0);
        @(posedge CLOCK_50_I); #1;
        chk("after_clr", 32'(cc0), 32'd3);
        drain("sat");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
